controle_ponto_flt: RTL and testbench

Issue-side controller for the floating-point unit `UnidadePontoFlt`. It accepts single-precision add/multiply requests from the processor pipeline and drives the FPU's `start`/`multiplicando`/`a`/`b` inputs. It waits for the FPU's `finish`, then returns `s` to the pipeline through a valid/ready response port. It is the initiator for the FPU's start/finish protocol and serialises one operation at a time.

---
 rtl/controle_ponto_flt.sv | 136 +++++++++++++
 tb/tb_controle_ponto_flt.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/controle_ponto_flt.sv
// Issue-side controller for UnidadePontoFlt: serialises add/multiply requests onto the FPU
// start/finish handshake and returns results over a valid/ready port. Optional macro: FPU_TIMEOUT_EN.
module controle_ponto_flt #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd,
  output logic        fpu_start,
  output logic        fpu_multiplicando,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic [31:0] fpu_s,
  input  logic        fpu_finish,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_err,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic        start_q, start_d;
  logic        valid_q, valid_d;
  logic        mul_q;
  logic [31:0] a_q, b_q, data_q;
  logic [4:0]  rd_q;
  logic [15:0] cnt_q;
  logic        done_ok, done_tmo;

  assign done_ok = (state_q == S_WAIT) && fpu_finish;

`ifdef FPU_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tmo_q;
  logic          err_q;

  assign done_tmo = (state_q == S_WAIT) && !fpu_finish && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign resp_err = err_q;

  always_ff @(posedge clk) begin
    if (rst || state_q != S_WAIT) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (done_ok) begin
      err_q <= 1'b0;
    end else if (done_tmo) begin
      err_q <= 1'b1;
    end
  end
`else
  // Without the timeout build the parameter has no effect; error flag is constant low.
  localparam logic ERR_TIE = (TIMEOUT_CYCLES == 0) ? 1'b0 : 1'b0;
  assign done_tmo = 1'b0;
  assign resp_err = ERR_TIE;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (req_valid) state_d = S_WAIT;
      S_WAIT:  if (done_ok || done_tmo) state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = fpu_finish ? S_DRAIN : S_IDLE;
      S_DRAIN: if (!fpu_finish) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // start/valid are registered copies of the next state so the FPU sees glitch-free levels.
  always_comb begin
    req_ready = (state_q == S_IDLE);
    start_d   = (state_d == S_WAIT);
    valid_d   = (state_d == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      rd_q   <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (state_q == S_IDLE && req_valid) begin
        mul_q <= req_op;
        a_q   <= req_a;
        b_q   <= req_b;
        rd_q  <= req_rd;
      end
      if (done_ok) begin
        data_q <= fpu_s;
        cnt_q  <= cnt_q + 16'd1;
      end else if (done_tmo) begin
        data_q <= 32'h7FC0_0000;
      end
    end
  end

  assign fpu_start         = start_q;
  assign fpu_multiplicando = mul_q;
  assign fpu_a             = a_q;
  assign fpu_b             = b_q;
  assign resp_valid        = valid_q;
  assign resp_data         = data_q;
  assign resp_rd           = rd_q;
  assign op_count          = cnt_q;

endmodule

// File: tb/tb_controle_ponto_flt.sv
// Self-checking bench for controle_ponto_flt with a behavioural FPU and a response scoreboard.
// Timeout scenario runs only when FPU_TIMEOUT_EN is defined.
module tb_controle_ponto_flt;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_op, resp_ready, fpu_finish;
  logic [31:0] req_a, req_b, fpu_s;
  logic [4:0]  req_rd;
  logic        req_ready, fpu_start, fpu_multiplicando, resp_valid, resp_err;
  logic [31:0] fpu_a, fpu_b, resp_data;
  logic [4:0]  resp_rd;
  logic [15:0] op_count;

  controle_ponto_flt #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd), .fpu_start(fpu_start),
    .fpu_multiplicando(fpu_multiplicando), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_s(fpu_s),
    .fpu_finish(fpu_finish), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_rd(resp_rd), .resp_err(resp_err), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_total = 0;
  int          n_bad = 0;
  logic [15:0] exp_cnt = '0;

  // FPU model configuration, written only by the main process
  int          lat_cfg = 1;
  int          sticky_cfg = 0;
  logic [31:0] res_cfg = '0;
  int          inject_req = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Behavioural FPU: raises finish after lat_cfg start cycles, holds it sticky_cfg cycles after start falls.
  initial begin
    int wcyc = 0;
    int hold = 0;
    int inject_done = 0;
    fpu_finish = 1'b0;
    fpu_s = '0;
    forever begin
      @(posedge clk);
      #1;
      if (fpu_start) begin
        if (!fpu_finish) begin
          wcyc++;
          fpu_s = $urandom;
          if (wcyc >= lat_cfg) begin
            fpu_finish = 1'b1;
            fpu_s = res_cfg;
          end
        end
      end else begin
        wcyc = 0;
        fpu_s = $urandom;
        if (inject_req != inject_done) begin
          inject_done = inject_req;
          fpu_finish = 1'b1;
        end else if (fpu_finish) begin
          if (hold >= sticky_cfg) begin
            fpu_finish = 1'b0;
            hold = 0;
          end else begin
            hold++;
          end
        end
      end
    end
  end

  task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] res, input int lat,
                        input int sticky, input int bp, input bit tmo);
    exp_t e;
    int   n;
    logic prev_fin;
    lat_cfg = lat; sticky_cfg = sticky; res_cfg = res;
    req_op = op; req_a = a; req_b = b; req_rd = rd; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin step(); n++; end
    check("accept_wait", 32'(n < 200), 32'd1);
    sb.push_back(tmo ? exp_t'{32'h7FC0_0000, rd, 1'b1} : exp_t'{res, rd, 1'b0});
    if (!tmo) exp_cnt++;
    step();
    req_valid = 1'b0; req_op = ~op; req_a = $urandom; req_b = $urandom; req_rd = 5'($urandom);
    check("start_rise", 32'(fpu_start), 32'd1);
    check("fpu_a", fpu_a, a);
    check("fpu_b", fpu_b, b);
    check("fpu_mul", 32'(fpu_multiplicando), 32'(op));
    check("busy_ready", 32'(req_ready), 32'd0);
    n = 1;
    while (fpu_start && n < 2000) begin
      step();
      if (fpu_start) n++;
    end
    check("start_len", 32'(n), tmo ? 32'd16 : 32'(lat));
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("op_count", 32'(op_count), 32'(exp_cnt));
    if (bp > 0) begin
      req_valid = 1'b1;
      for (int i = 0; i < bp; i++) begin
        step();
        check("bp_valid", 32'(resp_valid), 32'd1);
        check("bp_data", resp_data, sb[0].data);
        check("bp_ready", 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
    end
    resp_ready = 1'b1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("resp_data", resp_data, e.data);
      check("resp_rd", 32'(resp_rd), 32'(e.rd));
      check("resp_err", 32'(resp_err), 32'(e.err));
    end
    prev_fin = fpu_finish;
    step();
    resp_ready = 1'b0;
    check("valid_drop", 32'(resp_valid), 32'd0);
    n = 0;
    while (prev_fin && n < 200) begin
      check("drain_ready", 32'(req_ready), 32'd0);
      check("drain_start", 32'(fpu_start), 32'd0);
      prev_fin = fpu_finish;
      step();
      n++;
    end
    if (bp == 0 && sticky > 0) check("drain_len", 32'(n), 32'(sticky));
    check("idle_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    bit any_valid;
    rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_a = '0; req_b = '0; req_rd = '0;
    resp_ready = 1'b0;
    step(); step();
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_start", 32'(fpu_start), 32'd0);
    check("rst_mul", 32'(fpu_multiplicando), 32'd0);
    check("rst_a", fpu_a, 32'd0);
    check("rst_b", fpu_b, 32'd0);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_data", resp_data, 32'd0);
    check("rst_rd", 32'(resp_rd), 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_count", 32'(op_count), 32'd0);
    rst = 1'b0;

    // reset three cycles into WAIT
    lat_cfg = 1000;
    req_op = 1'b1; req_a = 32'h4040_0000; req_b = 32'h4000_0000; req_rd = 5'd3; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    check("mid_start", 32'(fpu_start), 32'd1);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_start_off", 32'(fpu_start), 32'd0);
    check("mid_ready", 32'(req_ready), 32'd1);
    check("mid_a", fpu_a, 32'd0);
    any_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid) any_valid = 1'b1;
      step();
    end
    check("mid_no_valid", 32'(any_valid), 32'd0);
    check("mid_count", 32'(op_count), 32'(exp_cnt));

    // stray finish pulse while idle must be ignored
    sticky_cfg = 0;
    inject_req++;
    step(); step(); step();
    check("stray_valid", 32'(resp_valid), 32'd0);
    check("stray_ready", 32'(req_ready), 32'd1);
    check("stray_count", 32'(op_count), 32'(exp_cnt));

    run_op(1'b0, 32'h3F00_0000, 32'h3F00_0000, 5'd7, 32'h3F80_0000, 5, 0, 0, 1'b0);
    run_op(1'b1, 32'h3F00_0000, 32'h3F00_0000, 5'd12, 32'h3E80_0000, 3, 0, 10, 1'b0);
    run_op(1'b0, 32'h4120_0000, 32'hC0A0_0000, 5'd31, 32'h40A0_0000, 2, 4, 0, 1'b0);
    run_op(1'b1, 32'h4000_0000, 32'h4040_0000, 5'd1, 32'h40C0_0000, 1, 0, 0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      run_op(1'($urandom), $urandom, $urandom, 5'($urandom), $urandom,
             int'($urandom_range(1, 8)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), 1'b0);
    end
`ifdef FPU_TIMEOUT_EN
    run_op(1'b0, 32'h3F80_0000, 32'h3F80_0000, 5'd9, 32'h0, 1000, 0, 0, 1'b1);
`endif
    check("final_count", 32'(op_count), 32'(exp_cnt));
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
